// File: rtl/pll_sup_pkg.sv
// ----------------------------------------------------------------------------
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor: the sequencer state
// encoding and a constant-evaluable ceil(log2) helper used to size counters.
// ----------------------------------------------------------------------------
package pll_sup_pkg;

   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,   // pulsing pll_areset
      S_WAIT_LOCK = 3'd1,   // waiting for the synchronised lock flag
      S_STABLE    = 3'd2,   // lock seen, proving it stays up
      S_RELEASE   = 3'd3,   // staggered release of channel resets
      S_RUN       = 3'd4    // all channels out of reset, lock good
   } state_t;

   // Number of bits needed to represent values 0 .. value-1 (minimum 1).
   function automatic int clog2(input longint value);
      int w;
      w = 1;
      while ((64'd1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// ----------------------------------------------------------------------------
// pll_lock_supervisor_if
// Groups the PLL-side and reset-distribution signals of the supervisor.
//   pll_locked    PLL lock flag (asynchronous to clk)
//   force_relock  1-cycle request to restart the whole sequence
//   pll_areset    PLL reset request, active-high
//   ch_reset_out  per-domain resets, active-high, released bit 0 first
//   all_ready     all channels released and lock good
//   relock_count  saturating count of re-sequences from RELEASE/RUN
//   timeout_err   sticky lock-timeout flag
// master: the supervisor; slave: the board/PLL side.
// ----------------------------------------------------------------------------
interface pll_lock_supervisor_if #(
   parameter int NUM_CH = 3,
   parameter int CNT_W  = 8
);
   logic              pll_locked;
   logic              force_relock;
   logic              pll_areset;
   logic [NUM_CH-1:0] ch_reset_out;
   logic              all_ready;
   logic [CNT_W-1:0]  relock_count;
   logic              timeout_err;

   modport master (
      input  pll_locked, force_relock,
      output pll_areset, ch_reset_out, all_ready, relock_count, timeout_err
   );

   modport slave (
      output pll_locked, force_relock,
      input  pll_areset, ch_reset_out, all_ready, relock_count, timeout_err
   );
endinterface

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop single-bit synchroniser with synchronous active-high reset to 0.
//   clk    destination clock
//   reset  synchronous, active-high
//   d      asynchronous input bit
//   q      synchronised output (2-cycle latency)
// ----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic meta;

   // NOTE: non-blocking assignments make both flops sample on the same edge,
   // giving a true two-stage pipeline instead of a single collapsed flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// pll_lock_supervisor
// Pulses PLL areset, waits (with optional timeout) for a synchronised lock,
// requires the lock to hold for LOCK_STABLE_CYC consecutive cycles (the
// cycle that first sees lock counts as the first), then releases NUM_CH
// channel resets STAGGER_CYC apart. Loss of lock or force_relock from
// RELEASE/RUN re-sequences and bumps relock_count.
//   clk    board reference clock, free-running
//   reset  synchronous, active-high
//   bus    pll_lock_supervisor_if.master (see interface for signals)
// All outputs are registered.
// ----------------------------------------------------------------------------
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int NUM_CH           = 3,
   parameter int ARESET_CYC       = 16,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int LOCK_TIMEOUT_CYC = 1000000,
   parameter int STAGGER_CYC      = 64,
   parameter int CNT_W            = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   pll_lock_supervisor_if.master bus
);
   localparam int MAX_A   = (ARESET_CYC > LOCK_STABLE_CYC) ? ARESET_CYC : LOCK_STABLE_CYC;
   localparam int MAX_B   = (LOCK_TIMEOUT_CYC > STAGGER_CYC) ? LOCK_TIMEOUT_CYC : STAGGER_CYC;
   localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW      = clog2(MAX_CYC + 1);
   localparam int IW      = clog2(NUM_CH);

   localparam logic [CW-1:0] ARESET_LAST  = CW'(ARESET_CYC - 1);
   // The WAIT_LOCK cycle that first sees lock is stable cycle #1, so
   // STABLE itself has to cover LOCK_STABLE_CYC-1 further cycles.
   localparam logic [CW-1:0] STABLE_LAST  = CW'((LOCK_STABLE_CYC > 1) ? LOCK_STABLE_CYC - 2 : 0);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'((LOCK_TIMEOUT_CYC > 0) ? LOCK_TIMEOUT_CYC - 1 : 0);
   localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYC - 1);
   localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_CH - 1);

   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [IW-1:0]     idx, idx_n, idx_inc;
   logic [NUM_CH-1:0] ch_rst, ch_rst_n;
   logic              areset_q, areset_n;
   logic              ready_q, ready_n;
   logic              terr_q, terr_n;
   logic [CNT_W-1:0]  relock_q, relock_n;
   logic              lk;
   logic              go_restart, go_release;

   sync_2ff u_lock_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus.pll_locked),
      .q     (lk)
   );

   assign idx_inc = idx + IW'(1);

   // NOTE: every signal gets a default before the case so that no path
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      idx_n      = idx;
      ch_rst_n   = ch_rst;
      areset_n   = areset_q;
      ready_n    = 1'b0;
      terr_n     = terr_q;
      relock_n   = relock_q;
      go_restart = 1'b0;
      go_release = 1'b0;

      unique case (state)
         S_RESET_PLL: begin
            if (bus.force_relock) begin
               go_restart = 1'b1;
            end else if (cnt == ARESET_LAST) begin
               state_n  = S_WAIT_LOCK;
               cnt_n    = '0;
               areset_n = 1'b0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_WAIT_LOCK: begin
            if (bus.force_relock) begin
               go_restart = 1'b1;
            end else if (lk) begin
               if (LOCK_STABLE_CYC == 1) begin
                  go_release = 1'b1;
               end else begin
                  state_n = S_STABLE;
                  cnt_n   = '0;
               end
            end else if (LOCK_TIMEOUT_CYC > 0) begin
               if (cnt == TIMEOUT_LAST) begin
                  terr_n     = 1'b1;
                  go_restart = 1'b1;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
         end
         S_STABLE: begin
            if (bus.force_relock) begin
               go_restart = 1'b1;
            end else if (!lk) begin
               state_n = S_WAIT_LOCK;
               cnt_n   = '0;
            end else if (cnt == STABLE_LAST) begin
               go_release = 1'b1;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_RELEASE, S_RUN: begin
            if (!lk || bus.force_relock) begin
               go_restart = 1'b1;
               if (relock_q != '1) relock_n = relock_q + CNT_W'(1);
            end else if (state == S_RUN) begin
               ready_n = 1'b1;
            end else if (idx == IDX_LAST) begin
               // Only reachable with a single channel: bit 0 already free.
               state_n = S_RUN;
               cnt_n   = '0;
            end else if (cnt == STAGGER_LAST) begin
               ch_rst_n = ch_rst << 1;
               idx_n    = idx_inc;
               cnt_n    = '0;
               if (idx_inc == IDX_LAST) state_n = S_RUN;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: go_restart = 1'b1;
      endcase

      if (go_restart) begin
         state_n  = S_RESET_PLL;
         cnt_n    = '0;
         idx_n    = '0;
         ch_rst_n = '1;
         areset_n = 1'b1;
         ready_n  = 1'b0;
      end
      // Mask is a contiguous run of upper ones; shifting left frees the
      // lowest held bit, so channels can only ever release in order.
      if (go_release) begin
         state_n  = S_RELEASE;
         cnt_n    = '0;
         idx_n    = '0;
         ch_rst_n = ch_rst << 1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_RESET_PLL;
         cnt      <= '0;
         idx      <= '0;
         ch_rst   <= '1;
         areset_q <= 1'b1;
         ready_q  <= 1'b0;
         terr_q   <= 1'b0;
         relock_q <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         idx      <= idx_n;
         ch_rst   <= ch_rst_n;
         areset_q <= areset_n;
         ready_q  <= ready_n;
         terr_q   <= terr_n;
         relock_q <= relock_n;
      end
   end

   assign bus.pll_areset   = areset_q;
   assign bus.ch_reset_out = ch_rst;
   assign bus.all_ready    = ready_q;
   assign bus.relock_count = relock_q;
   assign bus.timeout_err  = terr_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Directed scenarios with literal expectations plus a randomized phase, all
// compared every cycle against a timestamp-based model of the sequencer.
// ----------------------------------------------------------------------------
module tb_pll_lock_supervisor;
   localparam int NUM_CH  = 3;
   localparam int ARESET  = 4;
   localparam int STABLE  = 8;
   localparam int TIMEOUT = 32;
   localparam int STAGGER = 4;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   t = 0;

   pll_lock_supervisor_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   pll_lock_supervisor #(
      .NUM_CH(NUM_CH), .ARESET_CYC(ARESET), .LOCK_STABLE_CYC(STABLE),
      .LOCK_TIMEOUT_CYC(TIMEOUT), .STAGGER_CYC(STAGGER), .CNT_W(CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // ---------------- behavioural model (timestamps, not states) -------------
   int cyc = 0;            // index of the current cycle
   bit model_valid = 0;
   bit s1, s2;             // lock flag delayed by two edges
   int seq_start;          // first cycle of the current areset pulse
   int wait_start;         // cycle from which the lock timeout is measured
   int lk_since;           // first cycle of current unbroken lock run, -1 none
   int rel0;               // cycle in which channel 0 became free, -1 none
   bit m_terr;
   int m_relocks;

   task automatic restart(input int s);
      seq_start  = s;
      wait_start = s + ARESET;
      lk_since   = -1;
      rel0       = -1;
   endtask

   initial begin
      forever begin
         int  n;
         bit  lk_now;
         @(posedge clk);
         n      = cyc;
         lk_now = s2;
         if (reset) begin
            s1 = 0; s2 = 0;
            restart(n + 1);
            m_terr = 0; m_relocks = 0;
            model_valid = 1;
         end else if (model_valid) begin
            s2 = s1; s1 = bus.pll_locked;
            if (rel0 >= 0) begin
               if (!lk_now || bus.force_relock) begin
                  if (m_relocks < CNT_MAX) m_relocks++;
                  restart(n + 1);
               end
            end else if (bus.force_relock) begin
               restart(n + 1);
            end else if (n < seq_start + ARESET) begin
               // areset pulse in progress
            end else if (lk_now) begin
               if (lk_since < 0) lk_since = n;
               if (n - lk_since + 1 == STABLE) rel0 = n + 1;
            end else if (lk_since >= 0) begin
               lk_since   = -1;
               wait_start = n + 1;
            end else if (n - wait_start + 1 == TIMEOUT) begin
               m_terr = 1;
               restart(n + 1);
            end
         end
         cyc = n + 1;
      end
   end

   // ---------------- per-cycle compare -------------------------------------
   initial begin
      forever begin
         int m, k;
         logic [NUM_CH-1:0] e_ch;
         logic e_areset, e_ready;
         @(negedge clk);
         if (model_valid) begin
            m = cyc;
            e_areset = (rel0 < 0) && (m < seq_start + ARESET);
            if (rel0 < 0) e_ch = '1;
            else begin
               k = (m - rel0) / STAGGER + 1;
               e_ch = (k >= NUM_CH) ? '0 : ({NUM_CH{1'b1}} << k);
            end
            e_ready = (rel0 >= 0) && (m >= rel0 + (NUM_CH - 1) * STAGGER + 1);
            check("model_pll_areset", 32'(bus.pll_areset), 32'(e_areset));
            check("model_ch_reset", 32'(bus.ch_reset_out), 32'(e_ch));
            check("model_all_ready", 32'(bus.all_ready), 32'(e_ready));
            check("model_relock_count", 32'(bus.relock_count), 32'(m_relocks));
            check("model_timeout_err", 32'(bus.timeout_err), 32'(m_terr));
         end
      end
   end

   // ---------------- stimulus helpers --------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic at(input int c);
      while (t < c) tick();
   endtask

   task automatic wait_ready(input string name, input int budget);
      int k = 0;
      while (!bus.all_ready && k < budget) begin tick(); k++; end
      check(name, 32'(bus.all_ready), 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      t = 0;
   endtask

   initial begin
      int hold;
      int k;
      reset = 1'b1;
      bus.pll_locked   = 1'b0;
      bus.force_relock = 1'b0;
      tick();
      check("reset_areset", 32'(bus.pll_areset), 32'd1);
      check("reset_ch", 32'(bus.ch_reset_out), 32'b111);
      check("reset_ready", 32'(bus.all_ready), 32'd0);
      check("reset_count", 32'(bus.relock_count), 32'd0);
      check("reset_terr", 32'(bus.timeout_err), 32'd0);
      do_reset();

      // 1: bring-up with lock from cycle 10
      at(3);  check("t1_areset_c3", 32'(bus.pll_areset), 32'd1);
      at(4);  check("t1_areset_c4", 32'(bus.pll_areset), 32'd0);
      at(10); bus.pll_locked = 1'b1;
      at(19); check("t1_ch_c19", 32'(bus.ch_reset_out), 32'b111);
      at(20); check("t1_ch_c20", 32'(bus.ch_reset_out), 32'b110);
      at(23); check("t1_ch_c23", 32'(bus.ch_reset_out), 32'b110);
      at(24); check("t1_ch_c24", 32'(bus.ch_reset_out), 32'b100);
      at(28); check("t1_ch_c28", 32'(bus.ch_reset_out), 32'b000);
              check("t1_ready_c28", 32'(bus.all_ready), 32'd0);
      at(29); check("t1_ready_c29", 32'(bus.all_ready), 32'd1);

      // 4: lock loss in RUN
      at(40); bus.pll_locked = 1'b0;
      at(42); check("t4_ch_c42", 32'(bus.ch_reset_out), 32'b000);
      at(43); check("t4_ch_c43", 32'(bus.ch_reset_out), 32'b111);
              check("t4_ready_c43", 32'(bus.all_ready), 32'd0);
              check("t4_count_c43", 32'(bus.relock_count), 32'd1);
              check("t4_areset_c43", 32'(bus.pll_areset), 32'd1);
      at(46); check("t4_areset_c46", 32'(bus.pll_areset), 32'd1);
      at(47); check("t4_areset_c47", 32'(bus.pll_areset), 32'd0);

      // 3: one-cycle glitch in the stable window
      at(50); bus.pll_locked = 1'b1;
      at(55); bus.pll_locked = 1'b0;
      at(56); bus.pll_locked = 1'b1;
      at(65); check("t3_ch_c65", 32'(bus.ch_reset_out), 32'b111);
      at(66); check("t3_ch_c66", 32'(bus.ch_reset_out), 32'b110);
      at(74); check("t3_ch_c74", 32'(bus.ch_reset_out), 32'b000);
      at(75); check("t3_ready_c75", 32'(bus.all_ready), 32'd1);

      // 5: repeated forced relocks saturate the counter
      for (int i = 0; i < 5; i++) begin
         wait_ready("t5_wait_ready", 200);
         bus.force_relock = 1'b1;
         tick();
         bus.force_relock = 1'b0;
      end
      check("t5_count_sat", 32'(bus.relock_count), 32'd3);
      bus.pll_locked = 1'b0;
      repeat (6) tick();
      bus.force_relock = 1'b1;
      tick();
      bus.force_relock = 1'b0;
      check("t5_wait_force_areset", 32'(bus.pll_areset), 32'd1);
      check("t5_wait_force_count", 32'(bus.relock_count), 32'd3);

      // 6: reset in the middle of RELEASE
      do_reset();
      bus.pll_locked = 1'b1;
      k = 0;
      while (bus.ch_reset_out != 3'b100 && k < 200) begin tick(); k++; end
      check("t6_reach_100", 32'(bus.ch_reset_out), 32'b100);
      reset = 1'b1;
      tick();
      check("t6_areset", 32'(bus.pll_areset), 32'd1);
      check("t6_ch", 32'(bus.ch_reset_out), 32'b111);
      check("t6_ready", 32'(bus.all_ready), 32'd0);
      check("t6_count", 32'(bus.relock_count), 32'd0);
      check("t6_terr", 32'(bus.timeout_err), 32'd0);

      // 2: lock never arrives
      bus.pll_locked = 1'b0;
      do_reset();
      at(35); check("t2_terr_c35", 32'(bus.timeout_err), 32'd0);
      at(36); check("t2_terr_c36", 32'(bus.timeout_err), 32'd1);
              check("t2_areset_c36", 32'(bus.pll_areset), 32'd1);
      at(39); check("t2_areset_c39", 32'(bus.pll_areset), 32'd1);
      at(40); check("t2_areset_c40", 32'(bus.pll_areset), 32'd0);
      at(71); check("t2_areset_c71", 32'(bus.pll_areset), 32'd0);
      at(72); check("t2_areset_c72", 32'(bus.pll_areset), 32'd1);
              check("t2_ch_c72", 32'(bus.ch_reset_out), 32'b111);
              check("t2_count_c72", 32'(bus.relock_count), 32'd0);

      // randomized phase, checked by the model every cycle
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            bus.pll_locked = ($urandom_range(0, 9) < 7);
            hold = $urandom_range(1, 60);
         end
         hold--;
         bus.force_relock = ($urandom_range(0, 59) == 0);
         reset = ($urandom_range(0, 499) == 0);
         tick();
      end
      reset = 1'b0;
      bus.force_relock = 1'b0;
      repeat (3) tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
